// File: rtl/truth_table_scanner_if.sv
// Host/function-side bundle for truth_table_scanner; TT_COMPARE_EN adds the
// expected-table compare signals.
interface truth_table_scanner_if #(
  parameter int unsigned N_VARS = 4
);
  localparam int unsigned TT_W = 1 << N_VARS;

  logic              start;
  logic              f_i;
  logic              busy;
  logic              done;
  logic [N_VARS-1:0] vars_o;
  logic [TT_W-1:0]   truth_table;
  logic [N_VARS:0]   ones_count;
`ifdef TT_COMPARE_EN
  logic [TT_W-1:0]   expected_tt;
  logic              mismatch;
  logic [N_VARS-1:0] fail_index;

  modport master (
    output start, f_i, expected_tt,
    input  busy, done, vars_o, truth_table, ones_count, mismatch, fail_index
  );
  modport slave (
    input  start, f_i, expected_tt,
    output busy, done, vars_o, truth_table, ones_count, mismatch, fail_index
  );
`else
  modport master (
    output start, f_i,
    input  busy, done, vars_o, truth_table, ones_count
  );
  modport slave (
    input  start, f_i,
    output busy, done, vars_o, truth_table, ones_count
  );
`endif
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an N_VARS-input function, holding each for
// SETTLE_CYCLES, and assembles its truth table and ones count. Optional TT_COMPARE_EN.
module truth_table_scanner #(
  parameter int unsigned N_VARS        = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_scanner_if.slave bus
);
  localparam int unsigned TT_W  = 1 << N_VARS;
  localparam int unsigned OC_W  = N_VARS + 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_VARS-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t            state_q, state_n;
  logic [N_VARS-1:0] idx_q, idx_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [N_VARS-1:0] vars_q, vars_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [TT_W-1:0]   tt_q, tt_n;
  logic [OC_W-1:0]   oc_q, oc_n;
`ifdef TT_COMPARE_EN
  logic [TT_W-1:0]   exp_q, exp_n;
  logic              mm_q, mm_n;
  logic [N_VARS-1:0] fi_q, fi_n;
`endif

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vars_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      oc_q    <= '0;
`ifdef TT_COMPARE_EN
      exp_q   <= '0;
      mm_q    <= 1'b0;
      fi_q    <= '0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      vars_q  <= vars_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      tt_q    <= tt_n;
      oc_q    <= oc_n;
`ifdef TT_COMPARE_EN
      exp_q   <= exp_n;
      mm_q    <= mm_n;
      fi_q    <= fi_n;
`endif
    end
  end

  // Next-state: accept in IDLE/DONE, otherwise count down and sample per vector
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    vars_n  = vars_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    tt_n    = tt_q;
    oc_n    = oc_q;
`ifdef TT_COMPARE_EN
    exp_n   = exp_q;
    mm_n    = mm_q;
    fi_n    = fi_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = SETTLE;
          idx_n   = '0;
          cnt_n   = RELOAD;
          vars_n  = '0;
          busy_n  = 1'b1;
          tt_n    = '0;
          oc_n    = '0;
`ifdef TT_COMPARE_EN
          exp_n   = bus.expected_tt;
          mm_n    = 1'b0;
          fi_n    = '0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          tt_n[idx_q] = bus.f_i;
          oc_n        = oc_q + OC_W'(bus.f_i);
`ifdef TT_COMPARE_EN
          // Only the first disagreeing vector is recorded
          if (bus.f_i != exp_q[idx_q]) begin
            mm_n = 1'b1;
            if (!mm_q) fi_n = idx_q;
          end
`endif
          if (idx_q == IDX_LAST) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n  = idx_q + N_VARS'(1);
            vars_n = idx_q + N_VARS'(1);
            cnt_n  = RELOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.vars_o      = vars_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.ones_count  = oc_q;
`ifdef TT_COMPARE_EN
  assign bus.mismatch    = mm_q;
  assign bus.fail_index  = fi_q;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed self-checking bench for truth_table_scanner with a result scoreboard;
// compare-port checks compile in when TT_COMPARE_EN is defined.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_scanner_if #(.N_VARS(4)) bus1 ();
  truth_table_scanner_if #(.N_VARS(4)) bus3 ();

  truth_table_scanner #(.N_VARS(4), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  truth_table_scanner #(.N_VARS(4), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // mode 0: reference function, 1: tied 0, 2: tied 1
  int   mode1, mode3;
  logic start1, start3;
  bit   sel3;
  logic [15:0] exp1, exp3;

  function automatic logic f_of(input int mode, input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ~((~a & b) | (b & c)) | (a & ~d) | (b & d);
    endcase
  endfunction

  assign bus1.start = start1;
  assign bus3.start = start3;
  assign bus1.f_i   = f_of(mode1, bus1.vars_o);
  assign bus3.f_i   = f_of(mode3, bus3.vars_o);

  logic [3:0]  obs_vars;
  logic        obs_busy, obs_done;
  logic [15:0] obs_tt;
  logic [4:0]  obs_oc;
  assign obs_vars = sel3 ? bus3.vars_o      : bus1.vars_o;
  assign obs_busy = sel3 ? bus3.busy        : bus1.busy;
  assign obs_done = sel3 ? bus3.done        : bus1.done;
  assign obs_tt   = sel3 ? bus3.truth_table : bus1.truth_table;
  assign obs_oc   = sel3 ? bus3.ones_count  : bus1.ones_count;
`ifdef TT_COMPARE_EN
  logic       obs_mm;
  logic [3:0] obs_fi;
  assign bus1.expected_tt = exp1;
  assign bus3.expected_tt = exp3;
  assign obs_mm = sel3 ? bus3.mismatch   : bus1.mismatch;
  assign obs_fi = sel3 ? bus3.fail_index : bus1.fail_index;
`endif

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  oc;
    logic        mm;
    logic [3:0]  fi;
  } exp_t;
  exp_t sb[$];
  exp_t last;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_start(input bit s3, input logic v);
    if (s3) start3 = v; else start1 = v;
  endtask

  // Pulse start for the acceptance edge; returns at the first negedge after it
  task automatic start_scan(input bit s3, input logic [15:0] tt, input logic [4:0] oc,
                            input logic mm, input logic [3:0] fi, input bit push);
    exp_t e;
    sel3 = s3;
    @(negedge clk);
    drv_start(s3, 1'b1);
    e.tt = tt; e.oc = oc; e.mm = mm; e.fi = fi;
    if (push) sb.push_back(e);
    @(negedge clk);
  endtask

  // Walks a scan from its first negedge to the done cycle, checking every cycle
  task automatic run_body(input bit s3, input int settle, input bit poke, input bit chain);
    int lst;
    lst  = 16 * settle;
    sel3 = s3;
    for (int n = 0; n <= lst; n++) begin
      if (n > 0) @(negedge clk);
      drv_start(s3, (poke && n == 5) || (chain && n >= lst - 1));
`ifdef TT_COMPARE_EN
      if (n == 0) begin
        chk("mismatch_clear", 32'(obs_mm), 0);
        chk("fail_index_clear", 32'(obs_fi), 0);
      end
`endif
      if (n < lst) begin
        chk("vars_step", 32'(obs_vars), 32'(n / settle));
        chk("busy_scan", 32'(obs_busy), 1);
        chk("done_early", 32'(obs_done), 0);
      end else begin
        chk("done_pulse", 32'(obs_done), 1);
        chk("busy_end", 32'(obs_busy), 0);
        chk("vars_last", 32'(obs_vars), 15);
        chk("sb_size", 32'(sb.size()), 1);
        if (sb.size() > 0) begin
          last = sb.pop_front();
          chk("truth_table", 32'(obs_tt), 32'(last.tt));
          chk("ones_count", 32'(obs_oc), 32'(last.oc));
`ifdef TT_COMPARE_EN
          chk("mismatch", 32'(obs_mm), 32'(last.mm));
          chk("fail_index", 32'(obs_fi), 32'(last.fi));
`endif
        end
      end
    end
  endtask

  // Cycle after done: back to idle with results held
  task automatic idle_check(input bit s3);
    sel3 = s3;
    @(negedge clk);
    drv_start(s3, 1'b0);
    chk("done_drop", 32'(obs_done), 0);
    chk("busy_idle", 32'(obs_busy), 0);
    chk("vars_hold", 32'(obs_vars), 15);
    chk("tt_hold", 32'(obs_tt), 32'(last.tt));
    chk("oc_hold", 32'(obs_oc), 32'(last.oc));
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    mode1 = 0; mode3 = 0; sel3 = 1'b0;
    exp1 = 16'hFFAF; exp3 = 16'hFFAF;
    repeat (2) @(negedge clk);
    chk("rst_vars", 32'(bus1.vars_o), 0);
    chk("rst_busy", 32'(bus1.busy), 0);
    chk("rst_done", 32'(bus1.done), 0);
    chk("rst_tt", 32'(bus1.truth_table), 0);
    chk("rst_oc", 32'(bus1.ones_count), 0);
    chk("rst_busy3", 32'(bus3.busy), 0);
    rst = 1'b0;

    // Reference function, one cycle per vector
    start_scan(0, 16'hFFAF, 5'd14, 1'b0, 4'd0, 1);
    run_body(0, 1, 0, 0);
    idle_check(0);

    // Constant functions
    mode1 = 1; exp1 = 16'h0000;
    start_scan(0, 16'h0000, 5'd0, 1'b0, 4'd0, 1);
    run_body(0, 1, 0, 0);
    idle_check(0);
    mode1 = 2; exp1 = 16'hFFFF;
    start_scan(0, 16'hFFFF, 5'd16, 1'b0, 4'd0, 1);
    run_body(0, 1, 0, 0);
    idle_check(0);

    // Three-cycle settle
    start_scan(1, 16'hFFAF, 5'd14, 1'b0, 4'd0, 1);
    run_body(1, 3, 0, 0);
    idle_check(1);

    // Ignored mid-scan start, then start held through done for a back-to-back scan
    mode1 = 0; exp1 = 16'hFFAF;
    start_scan(0, 16'hFFAF, 5'd14, 1'b0, 4'd0, 1);
    run_body(0, 1, 1, 1);
    e.tt = 16'hFFAF; e.oc = 5'd14; e.mm = 1'b0; e.fi = 4'd0;
    sb.push_back(e);
    @(negedge clk);
    chk("b2b_busy", 32'(bus1.busy), 1);
    chk("b2b_done", 32'(bus1.done), 0);
    chk("b2b_vars", 32'(bus1.vars_o), 0);
    chk("b2b_tt", 32'(bus1.truth_table), 0);
    chk("b2b_oc", 32'(bus1.ones_count), 0);
    run_body(0, 1, 0, 0);
    idle_check(0);

    // Reset mid-scan at vector 7
    start_scan(0, 16'hFFAF, 5'd14, 1'b0, 4'd0, 0);
    for (int n = 0; n < 7; n++) begin
      if (n > 0) @(negedge clk);
      drv_start(0, 1'b0);
    end
    @(negedge clk);
    chk("pre_rst_vars", 32'(bus1.vars_o), 7);
    rst = 1'b1;
    #1;
    chk("arst_vars", 32'(bus1.vars_o), 0);
    chk("arst_busy", 32'(bus1.busy), 0);
    chk("arst_tt", 32'(bus1.truth_table), 0);
    chk("arst_oc", 32'(bus1.ones_count), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus1.busy), 0);
    chk("post_rst_vars", 32'(bus1.vars_o), 0);
    start_scan(0, 16'hFFAF, 5'd14, 1'b0, 4'd0, 1);
    run_body(0, 1, 0, 0);
    idle_check(0);

`ifdef TT_COMPARE_EN
    // Disagreeing expectation: first failing vector is 4, then cleared on restart
    exp1 = 16'hFFFF;
    start_scan(0, 16'hFFAF, 5'd14, 1'b1, 4'd4, 1);
    run_body(0, 1, 0, 0);
    idle_check(0);
    exp1 = 16'hFFAF;
    start_scan(0, 16'hFFAF, 5'd14, 1'b0, 4'd0, 1);
    run_body(0, 1, 0, 0);
    idle_check(0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
